// File: rtl/slt_pkg.sv
// Shared types and constants for the iterative set-less-than unit.
package slt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sltState_e;

  localparam int unsigned FLAG_W  = 3;
  localparam int unsigned FLAG_GT = 0;
  localparam int unsigned FLAG_EQ = 1;
  localparam int unsigned FLAG_LT = 2;

  // Build the one-hot gt/eq/lt flag vector from a decided gt/lt pair.
  function automatic logic [FLAG_W-1:0] packFlags(input logic gt, input logic lt);
    logic [FLAG_W-1:0] f;
    f          = '0;
    f[FLAG_GT] = gt;
    f[FLAG_LT] = lt;
    f[FLAG_EQ] = ~(gt | lt);
    return f;
  endfunction

endpackage

// File: rtl/chunk_compare.sv
// Unsigned magnitude compare of two CHUNK-bit slices (combinational).
module chunk_compare #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] iA,
  input  logic [CHUNK-1:0] iB,
  output logic             oGt_c,
  output logic             oEq_c,
  output logic             oLt_c
);

  // Three-way unsigned compare of the selected slices.
  always_comb begin
    oGt_c = (iA > iB);
    oEq_c = (iA == iB);
    oLt_c = (iA < iB);
  end

endmodule

// File: rtl/iterative_set_less_than.sv
// Multi-cycle SLT/SLTU: compares CHUNK bits per cycle from the MSB down.
// Optional build macro SLT_EARLY_EXIT_EN: finish on the first differing chunk.
module iterative_set_less_than
  import slt_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iValid,
  output logic              oReady,
  input  logic              iSigned,
  input  logic [WIDTH-1:0]  iDataA,
  input  logic [WIDTH-1:0]  iDataB,
  output logic              oValid,
  input  logic              iReady,
  output logic [WIDTH-1:0]  oData,
  output logic [FLAG_W-1:0] oFlags
);

  localparam int unsigned NCHUNK = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  // Reject configurations where the operand does not split into whole chunks.
  generate
    if ((CHUNK == 0) || ((WIDTH % ((CHUNK == 0) ? 1 : CHUNK)) != 0)) begin : gBadCfg
      $error("iterative_set_less_than: WIDTH must be a nonzero multiple of CHUNK");
    end
  endgenerate

  sltState_e        state;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [IDX_W-1:0] idx;
  logic             decided;
  logic             gtReg;
  logic             ltReg;

  logic [CHUNK-1:0] sliceA;
  logic [CHUNK-1:0] sliceB;
  logic             cmpGt;
  logic             cmpEq;
  logic             cmpLt;
  logic             nextGt;
  logic             nextLt;
  logic             nextDecided;
  logic             finishBusy;
  logic [WIDTH-1:0] signFlip;

  // Select the chunk addressed by idx from both latched operands.
  always_comb begin
    sliceA = '0;
    sliceB = '0;
    for (int i = 0; i < int'(NCHUNK); i++) begin
      if (idx == IDX_W'(i)) begin
        sliceA = aReg[i*CHUNK +: CHUNK];
        sliceB = bReg[i*CHUNK +: CHUNK];
      end
    end
  end

  chunk_compare #(
    .CHUNK (CHUNK)
  ) uChunkCompare (
    .iA    (sliceA),
    .iB    (sliceB),
    .oGt_c (cmpGt),
    .oEq_c (cmpEq),
    .oLt_c (cmpLt)
  );

  // Fold the current chunk result into the running decision.
  always_comb begin
    signFlip            = '0;
    signFlip[WIDTH-1]   = iSigned;
    nextDecided         = decided | ~cmpEq;
    nextGt              = decided ? gtReg : cmpGt;
    nextLt              = decided ? ltReg : cmpLt;
`ifdef SLT_EARLY_EXIT_EN
    finishBusy          = (idx == '0) || nextDecided;
`else
    finishBusy          = (idx == '0);
`endif
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state   <= IDLE;
      oReady  <= 1'b0;
      oValid  <= 1'b0;
      oData   <= '0;
      oFlags  <= '0;
      aReg    <= '0;
      bReg    <= '0;
      idx     <= '0;
      decided <= 1'b0;
      gtReg   <= 1'b0;
      ltReg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          oReady <= 1'b1;
          oValid <= 1'b0;
          if (iValid && oReady) begin
            // Flipping the sign bit maps two's complement order onto unsigned order.
            aReg    <= iDataA ^ signFlip;
            bReg    <= iDataB ^ signFlip;
            idx     <= IDX_W'(NCHUNK - 1);
            decided <= 1'b0;
            gtReg   <= 1'b0;
            ltReg   <= 1'b0;
            oReady  <= 1'b0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          gtReg   <= nextGt;
          ltReg   <= nextLt;
          decided <= nextDecided;
          idx     <= idx - IDX_W'(1);
          if (finishBusy) begin
            oValid <= 1'b1;
            oData  <= WIDTH'(nextLt);
            oFlags <= packFlags(nextGt, nextLt);
            state  <= DONE;
          end
        end
        DONE: begin
          if (iReady) begin
            oValid <= 1'b0;
            oReady <= 1'b1;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_set_less_than.sv
// Scoreboard bench for iterative_set_less_than (WIDTH=32, CHUNK=8).
module tb_iterative_set_less_than;

  localparam int NCHUNK = 4;

  logic        clk = 1'b0;
  logic        iRst;
  logic        iValid;
  logic        oReady;
  logic        iSigned;
  logic [31:0] iDataA;
  logic [31:0] iDataB;
  logic        oValid;
  logic        iReady;
  logic [31:0] oData;
  logic [2:0]  oFlags;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  flags;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sbQ[$];

  iterative_set_less_than #(.WIDTH(32), .CHUNK(8)) dut (
    .iClk    (clk),
    .iRst    (iRst),
    .iValid  (iValid),
    .oReady  (oReady),
    .iSigned (iSigned),
    .iDataA  (iDataA),
    .iDataB  (iDataB),
    .oValid  (oValid),
    .iReady  (iReady),
    .oData   (oData),
    .oFlags  (oFlags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected cycles from accept to oValid for a given operand pair.
  function automatic int expLat(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] ea;
    logic [31:0] eb;
    ea = a;
    eb = b;
    if (s) begin
      ea[31] = ~ea[31];
      eb[31] = ~eb[31];
    end
    for (int i = NCHUNK - 1; i >= 0; i--) begin
      if (ea[i*8 +: 8] != eb[i*8 +: 8]) begin
`ifdef SLT_EARLY_EXIT_EN
        return NCHUNK - i;
`else
        return NCHUNK;
`endif
      end
    end
    return NCHUNK;
  endfunction

  // Monitor: latency on each oValid rise, result on each handshake, stability under backpressure.
  logic        prevValid = 1'b0;
  logic        prevIReady = 1'b0;
  logic [31:0] prevData = '0;
  logic [2:0]  prevFlags = '0;

  always @(negedge clk) begin
    exp_t e;
    if (iRst) begin
      prevValid = 1'b0;
    end else begin
      if (prevValid && !prevIReady) begin
        chk("hold_valid", 64'(oValid), 64'(1'b1));
        chk("hold_data", 64'(oData), 64'(prevData));
        chk("hold_flags", 64'(oFlags), 64'(prevFlags));
      end
      if (oValid && !prevValid) begin
        if (sbQ.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got oValid=1 expected 0 (cycle %0d)", cyc);
        end else begin
          chk("latency", 64'(cyc - sbQ[0].acc), 64'(sbQ[0].lat));
        end
      end
      if (oValid && iReady && sbQ.size() > 0) begin
        e = sbQ.pop_front();
        chk("result_data", 64'(oData), 64'(e.data));
        chk("result_flags", 64'(oFlags), 64'(e.flags));
      end
      prevValid  = oValid;
      prevIReady = iReady;
      prevData   = oData;
      prevFlags  = oFlags;
    end
  end

  // All driver steps are aligned to 1 time unit after a rising edge.
  task automatic waitReady();
    int n = 0;
    while (!oReady && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!oReady) begin
      total++;
      bad++;
      $display("FAIL wait_ready: got oReady=0 expected 1 within 100 cycles");
    end
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] b, input logic s,
                     input logic [31:0] d, input logic [2:0] f);
    exp_t e;
    waitReady();
    iDataA  = a;
    iDataB  = b;
    iSigned = s;
    iValid  = 1'b1;
    @(posedge clk);
    #1;
    e.data  = d;
    e.flags = f;
    e.lat   = expLat(a, b, s);
    e.acc   = cyc;
    sbQ.push_back(e);
    iValid  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbQ.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sbQ.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending results expected 0", sbQ.size());
      sbQ.delete();
    end
  endtask

  initial begin
    int n;
    iRst    = 1'b1;
    iValid  = 1'b0;
    iSigned = 1'b0;
    iDataA  = '0;
    iDataB  = '0;
    iReady  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(oReady), 64'(1'b0));
    chk("rst_valid", 64'(oValid), 64'(1'b0));
    chk("rst_data", 64'(oData), 64'(32'h0));
    chk("rst_flags", 64'(oFlags), 64'(3'b000));
    iRst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 64'(oReady), 64'(1'b1));

    // Directed vectors with hand-computed results.
    req(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'd1, 3'b100);
    req(32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 32'd0, 3'b001);
    req(32'h8000_0000, 32'h8000_0000, 1'b1, 32'd0, 3'b010);
    req(32'h8000_0000, 32'h8000_0000, 1'b0, 32'd0, 3'b010);
    req(32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 32'd1, 3'b100);
    req(32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 32'd0, 3'b001);
    req(32'h1234_5678, 32'h1234_5679, 1'b0, 32'd1, 3'b100);
    req(32'h0100_0000, 32'h00FF_FFFF, 1'b0, 32'd0, 3'b001);
    req(32'h1234_5678, 32'h1234_5678, 1'b0, 32'd0, 3'b010);
    req(32'h8000_0001, 32'h8000_0000, 1'b1, 32'd0, 3'b001);
    drain();

    // Backpressure: hold the result for 5 cycles while iValid toggles.
    iReady = 1'b0;
    req(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 32'd0, 3'b001);
    n = 0;
    while (!oValid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_valid_seen", 64'(oValid), 64'(1'b1));
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready_low", 64'(oReady), 64'(1'b0));
      iValid = ~iValid;
      iDataA = 32'h0000_0000;
      iDataB = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
    end
    iValid = 1'b0;
    iReady = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_ready_after", 64'(oReady), 64'(1'b1));
    chk("bp_valid_after", 64'(oValid), 64'(1'b0));
    chk("bp_data_kept", 64'(oData), 64'(32'd0));
    chk("bp_flags_kept", 64'(oFlags), 64'(3'b001));
    drain();

    // Reset on the second BUSY cycle abandons the operation.
    waitReady();
    iDataA  = 32'h1111_1111;
    iDataB  = 32'h2222_2222;
    iSigned = 1'b0;
    iValid  = 1'b1;
    @(posedge clk);
    #1;
    iValid = 1'b0;
    @(posedge clk);
    #1;
    iRst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ready_in_rst", 64'(oReady), 64'(1'b0));
    chk("abort_valid_in_rst", 64'(oValid), 64'(1'b0));
    iRst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_ready_after", 64'(oReady), 64'(1'b1));
    chk("abort_valid_after", 64'(oValid), 64'(1'b0));
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_pulse", 64'(oValid), 64'(1'b0));
    req(32'd5, 32'd7, 1'b0, 32'd1, 3'b100);
    drain();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iterative_set_less_than.md
Name: iterative_set_less_than

Overview:
- Parametrised, multi-cycle successor to the combinational SLTU path. Compares two WIDTH-bit operands CHUNK bits per cycle, starting at the MSB.
- Supports signed (SLT) and unsigned (SLTU) modes. Returns the zero-extended set-less-than result plus gt/eq/lt flags.
- Sits in the ALU execute path behind a valid/ready handshake, so wide operands need no long carry chain.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CHUNK, 8, bits compared per cycle. WIDTH must be divisible by CHUNK and CHUNK must be at least 1; any other value is an elaboration error.
- NCHUNK, WIDTH/CHUNK, derived local constant; not overridable.

Ports:
- iClk  input  1  clock, rising edge.
- iRst  input  1  synchronous, active-high reset.
- iValid  input  1  request valid.
- oReady  output  1  block can accept a request.
- iSigned  input  1  1 = SLT (two's complement), 0 = SLTU.
- iDataA  input  WIDTH  operand A.
- iDataB  input  WIDTH  operand B.
- oValid  output  1  result valid.
- iReady  input  1  consumer accepts the result.
- oData  output  WIDTH  1 if A < B under the selected mode, else 0 (zero-extended).
- oFlags  output  3  [0] A>B, [1] A==B, [2] A<B; exactly one bit set when oValid is high.

Behaviour:
- Single clock domain. iRst is sampled only on the rising edge of iClk.
- Reset: state IDLE; oReady=0 while iRst is high and 1 from the first cycle after; oValid=0, oData=0, oFlags=3'b000, internal registers cleared.
- States: IDLE, BUSY, DONE.
- IDLE: oReady=1, oValid=0. On an edge with iValid && oReady, accept the request and enter BUSY:
  - latch iDataA and iDataB;
  - if iSigned=1, invert bit WIDTH-1 of both latched operands, so an unsigned compare gives the signed order;
  - set chunk index = NCHUNK-1 and clear the decided flag.
- BUSY: oReady=0. Each cycle, compare chunk [idx*CHUNK +: CHUNK] of A and B as unsigned values.
  - If not yet decided and the chunks differ: latch gt/lt and set decided.
  - idx decrements each cycle.
  - On the edge that evaluates idx=0, go to DONE. If nothing was decided, the result is eq.
- DONE: oValid=1; oData = {WIDTH-1 zeros, lt}; oFlags holds the latched value.
  - oValid, oData and oFlags stay stable until iReady=1.
  - On an edge with oValid && iReady: go to IDLE, oValid=0. oData and oFlags keep their last value.
- Latency (default build): request accepted at edge k → oValid seen after edge k+NCHUNK. With defaults that is 4 cycles. Throughput: one result per NCHUNK+2 cycles.
- iValid and operand changes are ignored outside IDLE. There is no input buffering.
- Reset during BUSY or DONE: the operation is abandoned with no oValid pulse. The block returns to IDLE with reset values.
- iReady held high before DONE has no effect.
- NCHUNK=1 degenerates to a single BUSY cycle.

Optional Feature:
- Macro: SLT_EARLY_EXIT_EN.
- Defined: BUSY goes to DONE on the same edge that the first differing chunk is evaluated. Latency is (NCHUNK - idx_of_first_difference) cycles, minimum 1. Equal operands still take NCHUNK cycles.
- Not defined: fixed NCHUNK-cycle latency, as specified above.
- Results are identical in both builds.

Decomposition:
- Package slt_pkg holds:
  - state enum: IDLE, BUSY, DONE;
  - flag index constants: FLAG_GT=0, FLAG_EQ=1, FLAG_LT=2.
- Sub-module chunk_compare (parameter CHUNK): purely combinational, inputs two CHUNK-bit slices, outputs gt/eq/lt. Instantiated once; the FSM muxes the slice selected by idx into it.

Test Plan (WIDTH=32, CHUNK=8):
- iSigned=0, A=0x00000001, B=0xFFFFFFFF → oData=1, oFlags=3'b100, oValid 4 cycles after accept.
- iSigned=1, same operands → oData=0, oFlags=3'b001 (1 > -1).
- iSigned=1, A=B=0x80000000 → oData=0, oFlags=3'b010; repeat with iSigned=0 → same result.
- Backpressure: hold iReady=0 for 5 cycles in DONE → oValid, oData and oFlags stable. oReady stays 0 and a toggling iValid is ignored. Then iReady=1 → IDLE, oReady=1 on the next cycle.
- Assert iRst for 1 cycle on the 2nd BUSY cycle → oValid never pulses. oReady=0 during reset and 1 after. A new request (A=5, B=7, iSigned=0) gives oData=1.
- SLT_EARLY_EXIT_EN defined, A=0x01000000, B=0x00FFFFFF → oFlags=3'b001 after 1 cycle. A=B=0x12345678 → oFlags=3'b010 after 4 cycles.
